// File: rtl/bp_me_stream_arbiter.sv
// Round-robin arbiter sharing one BP Stream memory channel among num_req_p stream masters.
// A grant is held across all beats of a locked message so beats never interleave.
module bp_me_stream_arbiter #(
    parameter int unsigned num_req_p      = 2,
    parameter int unsigned header_width_p = 64,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned max_beats_p    = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_req_p*header_width_p-1:0]  req_header_i,
    input  logic [num_req_p*data_width_p-1:0]    req_data_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    output logic [num_req_p-1:0]                 req_ready_o,
    input  logic [num_req_p-1:0]                 req_lock_i,
    output logic [header_width_p-1:0]            mem_header_o,
    output logic [data_width_p-1:0]              mem_data_o,
    output logic                                 mem_v_o,
    input  logic                                 mem_ready_i,
    output logic                                 mem_lock_o,
    output logic [$clog2(num_req_p)-1:0]         grant_id_o,
    output logic                                 busy_o,
    output logic                                 protocol_err_o
);

    localparam int unsigned id_w  = $clog2(num_req_p);
    localparam int unsigned cnt_w = $clog2(max_beats_p + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [id_w-1:0]  r_rr_ptr;
    logic [id_w-1:0]  r_grant;
    logic [cnt_w-1:0] r_beat_cnt;
    logic             r_err;
    logic [id_w-1:0]  w_idx;
    logic [id_w-1:0]  w_win;
    logic [id_w-1:0]  w_sel;
    logic             w_found;
    logic             w_xfer;

    // Round-robin pick: first valid requester after the last message owner
    always_comb begin
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= num_req_p; k++) begin
            w_idx = id_w'((32'(r_rr_ptr) + k) % num_req_p);
            if (!w_found && req_v_i[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_sel  = (r_state == ST_LOCKED) ? r_grant : w_win;
    assign w_xfer = mem_v_o & mem_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a locked beat opens a message, an unlocked beat in LOCKED closes it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_xfer && mem_lock_o)  w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_xfer && !mem_lock_o) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output mux; everything is forced low while reset is held
    always_comb begin
        mem_header_o = '0;
        mem_data_o   = '0;
        mem_lock_o   = 1'b0;
        mem_v_o      = 1'b0;
        req_ready_o  = '0;
        if (reset_n_i && (r_state == ST_LOCKED || w_found)) begin
            for (int unsigned i = 0; i < num_req_p; i++) begin
                if (w_sel == id_w'(i)) begin
                    mem_header_o   = req_header_i[i*header_width_p +: header_width_p];
                    mem_data_o     = req_data_i[i*data_width_p +: data_width_p];
                    mem_lock_o     = req_lock_i[i];
                    mem_v_o        = req_v_i[i];
                    req_ready_o[i] = mem_ready_i;
                end
            end
        end
    end

    // Grant, round-robin pointer, beat counter and sticky overflow flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr_ptr   <= id_w'(num_req_p - 1);
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_xfer) begin
            if (r_state == ST_IDLE) begin
                r_grant <= w_win;
                if (mem_lock_o) begin
                    r_beat_cnt <= cnt_w'(1);
                end else begin
                    r_rr_ptr <= w_win;
                end
            end else begin
                if (r_beat_cnt == cnt_w'(max_beats_p)) begin
                    r_err <= 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + cnt_w'(1);
                end
                if (!mem_lock_o) begin
                    r_rr_ptr   <= r_grant;
                    r_beat_cnt <= '0;
                end
            end
        end
    end

    assign grant_id_o     = r_grant;
    assign busy_o         = (r_state == ST_LOCKED);
    assign protocol_err_o = r_err;

endmodule

// File: tb/tb_bp_me_stream_arbiter.sv
// Self-checking bench for bp_me_stream_arbiter: directed scenarios plus randomized traffic
// compared against an owner/last-winner message model.
module tb_bp_me_stream_arbiter;

    localparam int N  = 3;
    localparam int HW = 16;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*HW-1:0] req_header;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_v;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_lock;
    logic [HW-1:0]   mem_header;
    logic [DW-1:0]   mem_data;
    logic            mem_v;
    logic            mem_ready;
    logic            mem_lock;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            perr;

    always #5 clk = ~clk;

    bp_me_stream_arbiter #(
        .num_req_p(N), .header_width_p(HW), .data_width_p(DW), .max_beats_p(MB)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_header_i(req_header), .req_data_i(req_data),
        .req_v_i(req_v), .req_ready_o(req_ready), .req_lock_i(req_lock),
        .mem_header_o(mem_header), .mem_data_o(mem_data), .mem_v_o(mem_v),
        .mem_ready_i(mem_ready), .mem_lock_o(mem_lock),
        .grant_id_o(grant_id), .busy_o(busy), .protocol_err_o(perr)
    );

    int checks = 0;
    int errors = 0;

    // Message-level model: who owns the channel, who finished last, beats in current message
    int       m_owner;
    int       m_last;
    int       m_cnt;
    bit       m_err;
    int       m_gid;
    int       e_sel;
    bit       e_v;
    bit       e_lock;
    bit       e_xfer;
    logic [N-1:0] e_ready;

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_gid   = 0;
    endfunction

    function automatic void model_eval();
        e_v   = 1'b0;
        e_sel = 0;
        if (m_owner >= 0) begin
            e_sel = m_owner;
            e_v   = req_v[m_owner];
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!e_v && req_v[(m_last + k) % N]) begin
                    e_sel = (m_last + k) % N;
                    e_v   = 1'b1;
                end
            end
        end
        e_ready = '0;
        if (m_owner >= 0 || e_v) e_ready[e_sel] = mem_ready;
        e_lock = req_lock[e_sel];
        e_xfer = e_v && mem_ready;
    endfunction

    function automatic void model_commit();
        if (e_xfer) begin
            if (m_owner < 0) begin
                m_gid = e_sel;
                if (e_lock) begin
                    m_owner = e_sel;
                    m_cnt   = 1;
                end else begin
                    m_last = e_sel;
                end
            end else begin
                if (m_cnt + 1 > MB) m_err = 1'b1;
                else m_cnt = m_cnt + 1;
                if (!e_lock) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
        end
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] lock, input logic rdy);
        req_v     = v;
        req_lock  = lock;
        mem_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req_header[i*HW +: HW] = HW'($urandom);
            req_data[i*DW +: DW]   = DW'($urandom);
        end
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0, '0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive('1, '0, 1'b1);
        model_reset();
        @(negedge clk);
        checks++; if (mem_v !== 1'b0) begin errors++; $display("FAIL reset_mem_v: got %0b exp 0", mem_v); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b exp 000", req_ready); end
        checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_gid: got %0d exp 0", grant_id); end
        checks++; if ({busy, perr} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got %b exp 00", {busy, perr}); end
        rst_n = 1'b1;
        drive('1, '0, 1'b1);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL first_grant: got %b exp 001", req_ready); end
        tick();
        checks++; if (grant_id !== IW'(0)) begin errors++; $display("FAIL first_gid: got %0d exp 0", grant_id); end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 6; k++) begin
            drive(3'b011, 3'b000, 1'b1);
            checks++;
            if (req_ready !== ((k % 2 == 0) ? 3'b010 : 3'b001)) begin
                errors++; $display("FAIL alt_ready[%0d]: got %b exp %b", k, req_ready, (k % 2 == 0) ? 3'b010 : 3'b001);
            end
            tick();
            checks++;
            if (grant_id !== IW'((k % 2 == 0) ? 1 : 0)) begin
                errors++; $display("FAIL alt_gid[%0d]: got %0d exp %0d", k, grant_id, (k % 2 == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_lock_hold();
        int busy_cycles = 0;
        drive(3'b001, 3'b000, 1'b1);
        tick();
        for (int b = 0; b < 4; b++) begin
            drive(3'b011, (b < 3) ? 3'b010 : 3'b000, 1'b1);
            checks++;
            if (req_ready !== 3'b010 || mem_v !== 1'b1) begin
                errors++; $display("FAIL lock_hold[%0d]: got ready=%b v=%0b exp ready=010 v=1", b, req_ready, mem_v);
            end
            busy_cycles += int'(busy);
            tick();
        end
        checks++; if (busy_cycles != 3) begin errors++; $display("FAIL lock_busy_cycles: got %0d exp 3", busy_cycles); end
        drive(3'b011, 3'b000, 1'b1);
        checks++;
        if (req_ready !== 3'b001 || busy !== 1'b0) begin
            errors++; $display("FAIL lock_next_grant: got ready=%b busy=%0b exp ready=001 busy=0", req_ready, busy);
        end
        tick();
    endtask

    task automatic test_bubble();
        int beat = 2;
        drive(3'b100, 3'b100, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(3'b011, 3'b011, 1'b1);
            checks++;
            if (mem_v !== 1'b0 || req_ready !== 3'b100 || busy !== 1'b1) begin
                errors++; $display("FAIL bubble[%0d]: got v=%0b ready=%b busy=%0b exp v=0 ready=100 busy=1", c, mem_v, req_ready, busy);
            end
            tick();
        end
        for (int c = 0; c < 10 && beat <= 4; c++) begin
            drive(3'b111, {beat < 4, 2'b11}, 1'(c % 2));
            req_data[2*DW +: DW] = DW'(16'hB000 + beat);
            #1;
            checks++;
            if (mem_v !== 1'b1 || mem_data !== DW'(16'hB000 + beat) || mem_lock !== (beat < 4)
                || req_ready !== {1'(c % 2), 2'b00}) begin
                errors++; $display("FAIL bubble_beat%0d: got v=%0b data=%h lock=%0b ready=%b exp v=1 data=%h lock=%0b ready=%b",
                    beat, mem_v, mem_data, mem_lock, req_ready, 16'hB000 + beat, beat < 4, {1'(c % 2), 2'b00});
            end
            tick();
            if (c % 2 == 1) beat++;
        end
        checks++; if (beat != 5) begin errors++; $display("FAIL bubble_done: got beat %0d exp 5", beat); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), N'($urandom | $urandom), $urandom_range(0, 3) != 0);
            checks++;
            if (mem_v !== e_v || req_ready !== e_ready) begin
                errors++; $display("FAIL rnd_hs[%0d]: got v=%0b ready=%b exp v=%0b ready=%b", c, mem_v, req_ready, e_v, e_ready);
            end
            if (e_v) begin
                checks++;
                if (mem_header !== req_header[e_sel*HW +: HW] || mem_data !== req_data[e_sel*DW +: DW] || mem_lock !== e_lock) begin
                    errors++; $display("FAIL rnd_mux[%0d]: got hdr=%h data=%h lock=%0b exp hdr=%h data=%h lock=%0b", c,
                        mem_header, mem_data, mem_lock, req_header[e_sel*HW +: HW], req_data[e_sel*DW +: DW], e_lock);
                end
            end
            checks++;
            if (grant_id !== IW'(m_gid) || busy !== (m_owner >= 0) || perr !== m_err) begin
                errors++; $display("FAIL rnd_regs[%0d]: got gid=%0d busy=%0b err=%0b exp gid=%0d busy=%0b err=%0b", c,
                    grant_id, busy, perr, m_gid, m_owner >= 0, m_err);
            end
            tick();
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        for (int b = 1; b <= 9; b++) begin
            drive(3'b001, 3'b001, 1'b1);
            tick();
            checks++;
            if (perr !== (b >= 9)) begin errors++; $display("FAIL perr_beat%0d: got %0b exp %0b", b, perr, b >= 9); end
        end
        drive(3'b001, 3'b000, 1'b1);
        tick();
        drive(3'b000, 3'b000, 1'b1);
        tick();
        checks++;
        if (perr !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL perr_sticky: got err=%0b busy=%0b exp err=1 busy=0", perr, busy);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(3'b010, 3'b010, 1'b1);
        tick();
        drive(3'b010, 3'b010, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %0b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (busy !== 1'b0 || mem_v !== 1'b0 || req_ready !== '0 || grant_id !== '0) begin
            errors++; $display("FAIL midrst_async: got busy=%0b v=%0b ready=%b gid=%0d exp 0 0 000 0", busy, mem_v, req_ready, grant_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b011, 3'b000, 1'b1);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL midrst_winner: got %b exp 001", req_ready); end
        tick();
        checks++; if (grant_id !== IW'(0)) begin errors++; $display("FAIL midrst_gid: got %0d exp 0", grant_id); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_header = '0;
        req_data = '0;
        req_v = '0;
        req_lock = '0;
        mem_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_alternate();
        test_lock_hold();
        test_bubble();
        test_random();
        test_protocol_err();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
